axi_read_responder: RTL and testbench

// - Slave-side AXI read engine: accepts one AR request, then returns the full R burst from a synchronous SRAM.
// - Drives the R channel that the interconnect read-data mux arbitrates between slaves.
// - Instanced once per memory slave (ROM/IM/DM wrappers); one outstanding burst at a time.

---
 rtl/axi_read_responder.sv | 114 +++++++++++
 tb/tb_axi_read_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
// Slave-side AXI read engine: one AR request in, full R burst out of a synchronous SRAM.
// Optional AXI_RD_ERR_EN: out-of-range addresses return SLVERR beats without touching the SRAM.
module axi_read_responder #(
    parameter int IDS_W  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  ARID_S,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [IDS_W-1:0]  RID_S,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t            state;
    logic [3:0]        len;
    logic [3:0]        cnt;
    logic              fixed;
    logic              err;
    logic [MEM_AW-1:0] waddr;
    logic [MEM_AW-1:0] waddr_nxt;
    logic              req_err;
    logic              unused_ok;

`ifdef AXI_RD_ERR_EN
    assign req_err = |ARADDR[ADDR_W-1:MEM_AW+2];
`else
    assign req_err = 1'b0;
`endif

    // Size is fixed at one word; byte offset and (without error mode) upper bits alias away.
    assign unused_ok = ^{ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0], ARSIZE};

    // Word address wraps naturally at 2**MEM_AW.
    assign waddr_nxt = fixed ? waddr : waddr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ARREADY  <= 1'b1;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RDATA    <= '0;
            RID_S    <= '0;
            RRESP    <= 2'b00;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            len      <= '0;
            cnt      <= '0;
            fixed    <= 1'b0;
            err      <= 1'b0;
            waddr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ARVALID) begin
                        RID_S    <= ARID_S;
                        len      <= ARLEN;
                        fixed    <= (ARBURST == 2'b00);
                        err      <= req_err;
                        cnt      <= '0;
                        waddr    <= ARADDR[MEM_AW+1:2];
                        mem_addr <= ARADDR[MEM_AW+1:2];
                        mem_cs   <= ~req_err;
                        ARREADY  <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    mem_cs <= 1'b0;
                    state  <= DATA;
                end
                DATA: begin
                    if (!RVALID) begin
                        // SRAM data is valid this cycle; capture and hold it for the stall window.
                        RDATA  <= err ? '0 : mem_rdata;
                        RRESP  <= err ? 2'b10 : 2'b00;
                        RLAST  <= (cnt == len);
                        RVALID <= 1'b1;
                    end else if (RREADY) begin
                        RVALID <= 1'b0;
                        if (RLAST) begin
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt      <= cnt + 4'd1;
                            waddr    <= waddr_nxt;
                            mem_addr <= waddr_nxt;
                            mem_cs   <= ~err;
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder: stimulus pushes expected beats/addresses, a negedge monitor checks them.
module tb_axi_read_responder;
    localparam int IDS_W = 8, DATA_W = 32, ADDR_W = 32, MEM_AW = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [IDS_W-1:0]  ARID_S = '0;
    logic [ADDR_W-1:0] ARADDR = '0;
    logic [3:0]        ARLEN = '0;
    logic [2:0]        ARSIZE = 3'b010;
    logic [1:0]        ARBURST = 2'b01;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [IDS_W-1:0]  RID_S;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic              mem_cs;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    axi_read_responder #(.IDS_W(IDS_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst), .ARID_S(ARID_S), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID_S(RID_S), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .mem_cs(mem_cs),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
    always @(posedge clk) if (mem_cs) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    beat_t             exp_q[$];
    logic [MEM_AW-1:0] addr_q[$];
    int tests = 0;
    int fails = 0;
    int rr_mode = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [7:0] id, input logic last, input logic [1:0] resp);
        beat_t b;
        b.data = d; b.id = id; b.last = last; b.resp = resp;
        exp_q.push_back(b);
    endtask

    // RREADY either held high or toggled every cycle to create stalls.
    always @(posedge clk) begin
        #1;
        if (rr_mode == 1) RREADY = ~RREADY;
        else RREADY = 1'b1;
    end

    // Monitor: SRAM strobes, beat contents, hold-stability while stalled, R-handshake-to-RVALID gap.
    int          cyc = 0;
    int          hs_cyc = 0;
    logic        gap_pend = 1'b0;
    logic        prev_rv = 1'b0;
    logic        held_v = 1'b0;
    logic [42:0] held;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            addr_q.delete();
            held_v = 1'b0;
            gap_pend = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (mem_cs) begin
                if (addr_q.size() == 0) check("mem_cs_unexpected", 1, 0);
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (RVALID && !prev_rv && gap_pend) begin
                check("r_gap", cyc - hs_cyc, 3);
                gap_pend = 1'b0;
            end
            if (RVALID) begin
                if (held_v) check("stall_stable", {RDATA, RID_S, RLAST, RRESP}, held);
                if (RREADY) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                    else begin
                        beat_t b;
                        b = exp_q.pop_front();
                        check("rdata", RDATA, b.data);
                        check("rid", RID_S, b.id);
                        check("rlast", RLAST, b.last);
                        check("rresp", RRESP, b.resp);
                        if (!b.last) begin
                            gap_pend = 1'b1;
                            hs_cyc = cyc;
                        end
                    end
                end else begin
                    held = {RDATA, RID_S, RLAST, RRESP};
                    held_v = 1'b1;
                end
            end else held_v = 1'b0;
            prev_rv = RVALID;
        end
    end

    // Issue AR and return at handshake edge + 1; then check 2-cycle latency to RVALID.
    task automatic ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        int n = 0;
        @(posedge clk); #1;
        ARID_S = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'b010; ARVALID = 1'b1;
        @(negedge clk);
        while (!ARREADY && n < 100) begin @(negedge clk); n++; end
        check("ar_accept_timeout", n < 100, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 10) begin @(posedge clk); #1; n++; end
        check("ar_to_rvalid", n, 2);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("burst_done_timeout", n < 300, 1);
        check("addr_q_empty", addr_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_arready"}, ARREADY, 1);
        check({tag, "_rvalid"}, RVALID, 0);
        check({tag, "_rlast"}, RLAST, 0);
        check({tag, "_rdata"}, RDATA, 0);
        check({tag, "_rid"}, RID_S, 0);
        check({tag, "_rresp"}, RRESP, 0);
        check({tag, "_mem_cs"}, mem_cs, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = i;
        mem[0] = 32'h0BAD_0000;
        mem[2] = 32'hCAFE_0002;
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h8888_0008;
        mem[16383] = 32'h3FFF_1111;

        repeat (3) @(posedge clk);
        #1 check_reset_vals("in_reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_arready", ARREADY, 1);
        check("idle_rvalid", RVALID, 0);
        check("idle_mem_cs", mem_cs, 0);

        // Single beat, with ARREADY returning the cycle after the handshake.
        rr_mode = 0;
        addr_q.push_back(14'd4);
        exp_beat(32'hDEAD_BEEF, 8'h12, 1'b1, 2'b00);
        ar(8'h12, 32'h10, 4'd0, 2'b01);
        check("single_rlast_now", RLAST, 1);
        check("single_arready_low", ARREADY, 0);
        @(posedge clk); #1;
        check("single_arready_back", ARREADY, 1);
        check("single_rvalid_drop", RVALID, 0);
        wait_done();

        // INCR 4 beats with RREADY toggling.
        rr_mode = 1;
        for (int i = 0; i < 4; i++) addr_q.push_back(i[MEM_AW-1:0]);
        exp_beat(32'h0BAD_0000, 8'h21, 1'b0, 2'b00);
        exp_beat(32'h0000_0001, 8'h21, 1'b0, 2'b00);
        exp_beat(32'hCAFE_0002, 8'h21, 1'b0, 2'b00);
        exp_beat(32'h0000_0003, 8'h21, 1'b1, 2'b00);
        ar(8'h21, 32'h0, 4'd3, 2'b01);
        wait_done();

        // FIXED 3 beats, same word each time.
        rr_mode = 0;
        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(14'd2);
            exp_beat(32'hCAFE_0002, 8'h33, i == 2, 2'b00);
        end
        ar(8'h33, 32'h8, 4'd2, 2'b00);
        wait_done();

        // Word-address wrap at the top of the SRAM; 2'b11 burst behaves as INCR.
        addr_q.push_back(14'd16383);
        addr_q.push_back(14'd0);
        exp_beat(32'h3FFF_1111, 8'h44, 1'b0, 2'b00);
        exp_beat(32'h0BAD_0000, 8'h44, 1'b1, 2'b00);
        ar(8'h44, 32'hFFFC, 4'd1, 2'b11);
        wait_done();

        // Reset in the middle of beat 2 of an 8-beat burst.
        for (int i = 0; i < 8; i++) begin
            addr_q.push_back(14'd16 + i[MEM_AW-1:0]);
            exp_beat(32'd16 + i, 8'h55, i == 7, 2'b00);
        end
        ar(8'h55, 32'h40, 4'd7, 2'b01);
        n = 0;
        while (exp_q.size() > 6 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        n = 0;
        while (!RVALID && n < 10) begin @(posedge clk); #1; n++; end
        check("beat2_seen", RVALID, 1);
        rst = 1'b0;
        #1 check_reset_vals("mid_reset");
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        addr_q.push_back(14'd8);
        exp_beat(32'h8888_0008, 8'h5A, 1'b1, 2'b00);
        ar(8'h5A, 32'h20, 4'd0, 2'b01);
        wait_done();

`ifdef AXI_RD_ERR_EN
        // Out-of-range request: SLVERR beats, no SRAM access.
        exp_beat(32'h0, 8'h66, 1'b0, 2'b10);
        exp_beat(32'h0, 8'h66, 1'b1, 2'b10);
        ar(8'h66, 32'h0010_0000, 4'd1, 2'b01);
        wait_done();
`else
        // Upper address bits alias into the SRAM.
        addr_q.push_back(14'd4);
        exp_beat(32'hDEAD_BEEF, 8'h66, 1'b1, 2'b00);
        ar(8'h66, 32'h0010_0010, 4'd0, 2'b01);
        wait_done();
`endif

        repeat (3) @(posedge clk);
        #1 check("final_idle_arready", ARREADY, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
